// File: rtl/parity_pkg.sv
// Shared parity definitions: mode encoding and the parity function
// used by both the generator and checker datapaths.
package parity_pkg;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Widest word calc_parity accepts; callers zero-extend (parity unchanged)
   localparam int MAX_W = 1024;

   function automatic logic calc_parity(
      input logic [MAX_W-1:0] data,
      input logic             mode
   );
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/parity_checker.sv
// Combinational parity check of a received word plus its parity bit.
module parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              parity,
   input  logic              mode,
   output logic              error
);

   logic [MAX_W-1:0] data_ext;

   assign data_ext = MAX_W'(data);
   assign error    = calc_parity(data_ext, mode) ^ parity;

endmodule

// File: rtl/parity_generate.sv
// Combinational parity bit for one data word under even/odd mode.
module parity_generate
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              mode,
   output logic              parity
);

   logic [MAX_W-1:0] data_ext;

   assign data_ext = MAX_W'(data);
   assign parity   = calc_parity(data_ext, mode);

endmodule

// File: rtl/parity_gen_check.sv
// Registered parity generator and checker with sticky error flag
// and saturating error counter.
module parity_gen_check
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              gen_valid,
   input  logic [DATA_W-1:0] gen_data,
   output logic              gen_out_valid,
   output logic [DATA_W-1:0] gen_out_data,
   output logic              parity_bit,
   input  logic              chk_valid,
   input  logic [DATA_W-1:0] chk_data,
   input  logic              chk_parity,
   output logic              chk_out_valid,
   output logic              parity_error,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_count,
   input  logic              err_clear
);

   logic              gen_par;
   logic              chk_err;

   logic              gen_vld_d, gen_vld_q;
   logic [DATA_W-1:0] gen_data_d, gen_data_q;
   logic              par_d, par_q;
   logic              chk_vld_d, chk_vld_q;
   logic              err_d, err_q;
   logic              sticky_d, sticky_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   parity_generate #(.DATA_W(DATA_W)) u_gen (
      .data   (gen_data),
      .mode   (mode),
      .parity (gen_par)
   );

   parity_checker #(.DATA_W(DATA_W)) u_chk (
      .data   (chk_data),
      .parity (chk_parity),
      .mode   (mode),
      .error  (chk_err)
   );

   always_comb begin
      gen_vld_d  = gen_valid;
      gen_data_d = gen_valid ? gen_data : gen_data_q;
      par_d      = gen_valid & gen_par;
      chk_vld_d  = chk_valid;
      err_d      = chk_valid & chk_err;
      sticky_d   = sticky_q;
      cnt_d      = cnt_q;
      // Clear wins over a same-cycle error; the error still shows on parity_error
      if (err_clear) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (err_d) begin
         sticky_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gen_vld_q  <= 1'b0;
         gen_data_q <= '0;
         par_q      <= 1'b0;
         chk_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         gen_vld_q  <= gen_vld_d;
         gen_data_q <= gen_data_d;
         par_q      <= par_d;
         chk_vld_q  <= chk_vld_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
         cnt_q      <= cnt_d;
      end
   end

   assign gen_out_valid = gen_vld_q;
   assign gen_out_data  = gen_data_q;
   assign parity_bit    = par_q;
   assign chk_out_valid = chk_vld_q;
   assign parity_error  = err_q;
   assign err_sticky    = sticky_q;
   assign err_count     = cnt_q;

endmodule

// File: tb/tb_parity_gen_check.sv
// Randomized self-checking bench for parity_gen_check with a
// ones-counting reference model; a CNT_W=2 copy checks saturation.
module tb_parity_gen_check;
   import parity_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          gen_valid;
   logic [DW-1:0] gen_data;
   logic          chk_valid;
   logic [DW-1:0] chk_data;
   logic          chk_parity;
   logic          err_clear;

   logic          gen_out_valid, parity_bit, chk_out_valid;
   logic          parity_error, err_sticky;
   logic [DW-1:0] gen_out_data;
   logic [15:0]   err_count;

   logic          s_gov, s_pb, s_cov, s_pe, s_st;
   logic [DW-1:0] s_god;
   logic [1:0]    s_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic          m_gv, m_pb, m_cv, m_pe, m_st;
   logic [DW-1:0] m_gd;
   int            m_cnt, m_cnt2;

   always #5 clk = ~clk;

   parity_gen_check #(.DATA_W(DW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .gen_valid(gen_valid), .gen_data(gen_data),
      .gen_out_valid(gen_out_valid), .gen_out_data(gen_out_data),
      .parity_bit(parity_bit),
      .chk_valid(chk_valid), .chk_data(chk_data),
      .chk_parity(chk_parity),
      .chk_out_valid(chk_out_valid), .parity_error(parity_error),
      .err_sticky(err_sticky), .err_count(err_count),
      .err_clear(err_clear)
   );

   parity_gen_check #(.DATA_W(DW), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .mode(mode),
      .gen_valid(gen_valid), .gen_data(gen_data),
      .gen_out_valid(s_gov), .gen_out_data(s_god),
      .parity_bit(s_pb),
      .chk_valid(chk_valid), .chk_data(chk_data),
      .chk_parity(chk_parity),
      .chk_out_valid(s_cov), .parity_error(s_pe),
      .err_sticky(s_st), .err_count(s_cnt),
      .err_clear(err_clear)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit odd_ones(input logic [DW-1:0] d, input logic p);
      return (($countones(d) + int'(p)) % 2) == 1;
   endfunction

   // model next state from the inputs presented before the edge
   task automatic model_step();
      bit e;
      if (rst) begin
         m_gv = 0; m_gd = '0; m_pb = 0; m_cv = 0; m_pe = 0;
         m_st = 0; m_cnt = 0; m_cnt2 = 0;
         return;
      end
      m_gv = gen_valid;
      if (gen_valid) m_gd = gen_data;
      // parity bit makes total ones even (even mode) or odd (odd mode)
      m_pb = gen_valid && (odd_ones(gen_data, 1'b0) != (mode == PARITY_ODD));
      m_cv = chk_valid;
      e = chk_valid && (odd_ones(chk_data, chk_parity) != (mode == PARITY_ODD));
      m_pe = e;
      if (err_clear) begin
         m_st = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (e) begin
         m_st = 1;
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endtask

   task automatic compare_all();
      check("gen_out_valid", 32'(gen_out_valid), 32'(m_gv));
      check("gen_out_data", 32'(gen_out_data), 32'(m_gd));
      check("parity_bit", 32'(parity_bit), 32'(m_pb));
      check("chk_out_valid", 32'(chk_out_valid), 32'(m_cv));
      check("parity_error", 32'(parity_error), 32'(m_pe));
      check("err_sticky", 32'(err_sticky), 32'(m_st));
      check("err_count", 32'(err_count), 32'(m_cnt));
      check("s_err_count", 32'(s_cnt), 32'(m_cnt2));
      check("s_err_sticky", 32'(s_st), 32'(m_st));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      rst = 0; gen_valid = 0; chk_valid = 0; err_clear = 0;
      gen_data = '0; chk_data = '0; chk_parity = 0;
   endtask

   task automatic gen_vec(input logic m, input logic [DW-1:0] d,
                          input logic exp_p, input string tag);
      idle(); mode = m; gen_valid = 1; gen_data = d;
      cycle();
      check(tag, 32'(parity_bit), 32'(exp_p));
   endtask

   task automatic chk_beat(input logic m, input logic [DW-1:0] d,
                           input logic p, input logic clr);
      idle(); mode = m; chk_valid = 1; chk_data = d;
      chk_parity = p; err_clear = clr;
      cycle();
   endtask

   initial begin
      idle(); mode = PARITY_EVEN; rst = 1;
      m_gv = 0; m_gd = '0; m_pb = 0; m_cv = 0; m_pe = 0;
      m_st = 0; m_cnt = 0; m_cnt2 = 0;
      cycle(); cycle();
      check("rst_count", 32'(err_count), 32'd0);

      gen_vec(PARITY_EVEN, 8'b01010101, 1'b0, "even_55");
      gen_vec(PARITY_EVEN, 8'b11111110, 1'b1, "even_fe");
      gen_vec(PARITY_EVEN, 8'b00110001, 1'b1, "even_31");
      gen_vec(PARITY_EVEN, 8'b00110101, 1'b0, "even_35");
      gen_vec(PARITY_ODD,  8'b01010101, 1'b1, "odd_55");
      gen_vec(PARITY_ODD,  8'b11001100, 1'b1, "odd_cc");
      idle(); cycle();
      check("idle_pb", 32'(parity_bit), 32'd0);
      check("hold_data", 32'(gen_out_data), 32'(8'b11001100));

      // loopback: checker consumes last cycle's generator output
      for (int m = 0; m < 2; m++) begin
         for (int w = 0; w <= 256; w++) begin
            logic          pv, pp;
            logic [DW-1:0] pd;
            pv = gen_out_valid; pd = gen_out_data; pp = parity_bit;
            idle(); mode = m[0];
            gen_valid = (w < 256); gen_data = DW'(w);
            chk_valid = pv; chk_data = pd; chk_parity = pp;
            cycle();
            if (w > 0) check("loop_err", 32'(parity_error), 32'd0);
         end
      end
      check("loop_cnt", 32'(err_count), 32'd0);

      chk_beat(PARITY_EVEN, 8'b01010101, 1'b1, 1'b0);
      check("bad_even_err", 32'(parity_error), 32'd1);
      check("bad_even_cnt", 32'(err_count), 32'd1);
      check("bad_even_st", 32'(err_sticky), 32'd1);
      chk_beat(PARITY_ODD, 8'b01010101, 1'b0, 1'b0);
      check("bad_odd_err", 32'(parity_error), 32'd1);
      check("bad_odd_cnt", 32'(err_count), 32'd2);
      for (int i = 0; i < 3; i++)
         chk_beat(PARITY_EVEN, 8'h01, 1'b0, 1'b0);
      check("sat_cnt", 32'(s_cnt), 32'd3);
      check("big_cnt5", 32'(err_count), 32'd5);
      chk_beat(PARITY_EVEN, 8'h01, 1'b0, 1'b0);
      check("sat_hold", 32'(s_cnt), 32'd3);

      chk_beat(PARITY_EVEN, 8'h01, 1'b0, 1'b1);
      check("clr_err", 32'(parity_error), 32'd1);
      check("clr_cnt", 32'(err_count), 32'd0);
      check("clr_st", 32'(err_sticky), 32'd0);

      for (int i = 0; i < 400; i++) begin
         mode       = 1'($urandom);
         gen_valid  = 1'($urandom);
         gen_data   = DW'($urandom);
         chk_valid  = ($urandom_range(3) != 0);
         chk_data   = DW'($urandom);
         chk_parity = 1'($urandom);
         err_clear  = ($urandom_range(40) == 0);
         rst        = ($urandom_range(80) == 0);
         cycle();
      end

      idle(); mode = PARITY_EVEN;
      chk_beat(PARITY_EVEN, 8'h01, 1'b0, 1'b0);
      gen_valid = 1; gen_data = 8'hA5; chk_valid = 1; rst = 1;
      cycle();
      check("rst_gov", 32'(gen_out_valid), 32'd0);
      check("rst_god", 32'(gen_out_data), 32'd0);
      check("rst_pe", 32'(parity_error), 32'd0);
      check("rst_st", 32'(err_sticky), 32'd0);
      check("rst_cnt2", 32'(err_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
